ascon_perm_ctrl_2rc: RTL and testbench

ASCON_PERM_CTRL_2RC -- requirements
Module: ascon_perm_ctrl_2rc

---
 rtl/ascon_perm_ctrl_2rc.sv | 170 +++++++++++++++++
 tb/tb_ascon_perm_ctrl_2rc.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_perm_ctrl_2rc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ascon_perm_ctrl_2rc                                        |
// | Description : Sequencer for an external two-rounds-per-cycle Ascon       |
// |               permutation datapath. It accepts a 5x64 state, runs 12, 8  |
// |               or 6 rounds as NR/2 double-round cycles, and holds the     |
// |               registered result until the consumer takes it.             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module ascon_perm_ctrl_2rc #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    rounds,
  input  logic [DW-1:0] s_in0,
  input  logic [DW-1:0] s_in1,
  input  logic [DW-1:0] s_in2,
  input  logic [DW-1:0] s_in3,
  input  logic [DW-1:0] s_in4,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] s_out0,
  output logic [DW-1:0] s_out1,
  output logic [DW-1:0] s_out2,
  output logic [DW-1:0] s_out3,
  output logic [DW-1:0] s_out4,
  input  logic          abort,
  output logic          dp_intial,
  output logic          dp_inc,
  output logic [3:0]    dp_constti,
  output logic [DW-1:0] dp_Xi0,
  output logic [DW-1:0] dp_Xi1,
  output logic [DW-1:0] dp_Xi2,
  output logic [DW-1:0] dp_Xi3,
  output logic [DW-1:0] dp_Xi4,
  input  logic [DW-1:0] dp_Xo0,
  input  logic [DW-1:0] dp_Xo1,
  input  logic [DW-1:0] dp_Xo2,
  input  logic [DW-1:0] dp_Xo3,
  input  logic [DW-1:0] dp_Xo4
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [2:0]    r_cnt;
  logic          r_out_valid;
  logic [DW-1:0] r_s_out0;
  logic [DW-1:0] r_s_out1;
  logic [DW-1:0] r_s_out2;
  logic [DW-1:0] r_s_out3;
  logic [DW-1:0] r_s_out4;

  logic          w_idle;
  logic [2:0]    w_half;
  logic [3:0]    w_const;

  assign w_idle = (r_state == c_IDLE);

  // Decode the round-count field into double-round count and first constant index
  always_comb begin
    w_half  = 3'd6;
    w_const = 4'd0;
    case (rounds)
      2'b01: begin
        w_half  = 3'd4;
        w_const = 4'd4;
      end
      2'b10: begin
        w_half  = 3'd3;
        w_const = 4'd6;
      end
      default: begin
        w_half  = 3'd6;
        w_const = 4'd0;
      end
    endcase
  end

  // Handshake and datapath steering, all decoded from the current state
  always_comb begin
    in_ready   = w_idle;
    // State is already IDLE during reset; rst gating keeps the load strobe quiet
    // even if a requester holds in_valid high while reset is asserted.
    dp_intial  = rst & w_idle & in_valid;
    dp_constti = dp_intial ? w_const : 4'd0;
    dp_inc     = (r_state == c_RUN) && (r_cnt > 3'd1);
    if (w_idle) begin
      dp_Xi0 = s_in0;
      dp_Xi1 = s_in1;
      dp_Xi2 = s_in2;
      dp_Xi3 = s_in3;
      dp_Xi4 = s_in4;
    end else begin
      dp_Xi0 = dp_Xo0;
      dp_Xi1 = dp_Xo1;
      dp_Xi2 = dp_Xo2;
      dp_Xi3 = dp_Xo3;
      dp_Xi4 = dp_Xo4;
    end
  end

  // Control FSM with double-round counter and result register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= c_IDLE;
      r_cnt       <= 3'd0;
      r_out_valid <= 1'b0;
      r_s_out0    <= '0;
      r_s_out1    <= '0;
      r_s_out2    <= '0;
      r_s_out3    <= '0;
      r_s_out4    <= '0;
    end else if (abort) begin
      // Cancel wins over accept and completion; the last result stays visible.
      r_state     <= c_IDLE;
      r_cnt       <= 3'd0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (in_valid) begin
            r_state <= c_RUN;
            r_cnt   <= w_half;
          end
        end
        c_RUN: begin
          if (r_cnt > 3'd1) begin
            r_cnt <= r_cnt - 3'd1;
          end else begin
            // Last double round is on dp_Xo now: capture it directly.
            r_s_out0    <= dp_Xo0;
            r_s_out1    <= dp_Xo1;
            r_s_out2    <= dp_Xo2;
            r_s_out3    <= dp_Xo3;
            r_s_out4    <= dp_Xo4;
            r_out_valid <= 1'b1;
            r_cnt       <= 3'd0;
            r_state     <= c_DONE;
          end
        end
        c_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= c_IDLE;
          end
        end
        default: begin
          r_state     <= c_IDLE;
          r_cnt       <= 3'd0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign s_out0    = r_s_out0;
  assign s_out1    = r_s_out1;
  assign s_out2    = r_s_out2;
  assign s_out3    = r_s_out3;
  assign s_out4    = r_s_out4;

endmodule
`default_nettype wire

// File: tb/tb_ascon_perm_ctrl_2rc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ascon_perm_ctrl_2rc                                     |
// | Description : Scoreboard bench for ascon_perm_ctrl_2rc with a behavioural|
// |               two-round Ascon datapath and a full-permutation reference. |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_ascon_perm_ctrl_2rc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, abort;
  logic [1:0]  rounds;
  logic [63:0] s_in0, s_in1, s_in2, s_in3, s_in4;
  logic [63:0] s_out0, s_out1, s_out2, s_out3, s_out4;
  logic        dp_intial, dp_inc;
  logic [3:0]  dp_constti;
  logic [63:0] dp_Xi0, dp_Xi1, dp_Xi2, dp_Xi3, dp_Xi4;
  logic [63:0] dp_Xo0, dp_Xo1, dp_Xo2, dp_Xo3, dp_Xo4;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  ascon_perm_ctrl_2rc #(.DW(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .rounds(rounds),
    .s_in0(s_in0), .s_in1(s_in1), .s_in2(s_in2), .s_in3(s_in3), .s_in4(s_in4),
    .out_valid(out_valid), .out_ready(out_ready),
    .s_out0(s_out0), .s_out1(s_out1), .s_out2(s_out2), .s_out3(s_out3), .s_out4(s_out4),
    .abort(abort), .dp_intial(dp_intial), .dp_inc(dp_inc), .dp_constti(dp_constti),
    .dp_Xi0(dp_Xi0), .dp_Xi1(dp_Xi1), .dp_Xi2(dp_Xi2), .dp_Xi3(dp_Xi3), .dp_Xi4(dp_Xi4),
    .dp_Xo0(dp_Xo0), .dp_Xo1(dp_Xo1), .dp_Xo2(dp_Xo2), .dp_Xo3(dp_Xo3), .dp_Xo4(dp_Xo4)
  );

  // ---------------- Ascon reference ----------------
  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [319:0] asc_round(input logic [319:0] s, input logic [3:0] i);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    logic [7:0]  c;
    {x0, x1, x2, x3, x4} = s;
    c  = {4'hf - i, i};
    x2 = x2 ^ {56'd0, c};
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  // Number of double rounds for a rounds code: 12, 8 or 6 rounds
  function automatic int half_of(input logic [1:0] r);
    return (r == 2'b10) ? 3 : (r == 2'b01) ? 4 : 6;
  endfunction

  // Full permutation: the last 2*half rounds of the 12-round schedule
  function automatic logic [319:0] ref_perm(input logic [319:0] s, input int half);
    logic [319:0] x;
    x = s;
    for (int k = 12 - 2 * half; k < 12; k++) x = asc_round(x, 4'(k));
    return x;
  endfunction

  function automatic logic [319:0] rand320();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- Behavioural 2-round datapath ----------------
  logic [319:0] dp_reg = '0;
  logic [3:0]   dp_idx = 4'd0;
  logic [319:0] dp_out;

  always @(posedge clk) begin
    dp_reg <= {dp_Xi0, dp_Xi1, dp_Xi2, dp_Xi3, dp_Xi4};
    if (dp_intial)   dp_idx <= dp_constti;
    else if (dp_inc) dp_idx <= dp_idx + 4'd2;
  end

  always_comb dp_out = asc_round(asc_round(dp_reg, dp_idx), dp_idx + 4'd1);
  assign {dp_Xo0, dp_Xo1, dp_Xo2, dp_Xo3, dp_Xo4} = dp_out;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- Checking ----------------
  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [319:0] exp;
    int           acc;
    int           half;
  } item_t;

  item_t        sb[$];
  logic         prev_ov = 1'b0;
  logic [319:0] held    = '0;

  // Monitor: push on handshake, pop and compare when a result appears
  always @(negedge clk) begin
    item_t it;
    if (!rst) begin
      sb.delete();
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          it = sb.pop_front();
          chk("result", {s_out0, s_out1, s_out2, s_out3, s_out4}, it.exp);
          chk("latency", cyc - it.acc, it.half);
        end
      end else if (out_valid) begin
        chk("done_hold", {s_out0, s_out1, s_out2, s_out3, s_out4}, held);
      end
      if (abort) begin
        sb.delete();
      end else if (in_valid && in_ready) begin
        it.half = half_of(rounds);
        it.exp  = ref_perm({s_in0, s_in1, s_in2, s_in3, s_in4}, it.half);
        it.acc  = cyc + 1;
        sb.push_back(it);
      end
      prev_ov = out_valid;
      held    = {s_out0, s_out1, s_out2, s_out3, s_out4};
    end
  end

  // ---------------- Stimulus ----------------
  task automatic set_sin(input logic [319:0] s);
    {s_in0, s_in1, s_in2, s_in3, s_in4} = s;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!in_ready && k < 30) begin @(posedge clk); #1; k++; end
    chk("idle_wait", in_ready, 1);
  endtask

  // One request; hold = cycles with out_ready low once the result appears
  task automatic run_req(input logic [1:0] r, input logic [319:0] s, input int hold);
    int half, lat, ninc;
    logic [319:0] cap;
    half = half_of(r);
    wait_idle();
    rounds = r; set_sin(s); in_valid = 1'b1; out_ready = (hold == 0);
    #1;
    chk("dp_intial", dp_intial, 1);
    chk("dp_constti", dp_constti, 12 - 2 * half);
    @(posedge clk); #1;
    in_valid = 1'b0; rounds = 2'($urandom); set_sin(rand320());
    chk("busy_ready", in_ready, 0);
    lat = 0; ninc = 0;
    while (!out_valid && lat < 20) begin
      if (dp_inc) ninc++;
      @(posedge clk); #1; lat++;
    end
    chk("edges_to_valid", lat, half);
    chk("dp_inc_cycles", ninc, half - 1);
    chk("dp_inc_done", dp_inc, 0);
    cap = {s_out0, s_out1, s_out2, s_out3, s_out4};
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
      chk("hold_data", {s_out0, s_out1, s_out2, s_out3, s_out4}, cap);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    chk("exit_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("exit_valid", out_valid, 0);
    chk("exit_idle", in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nacc, prev, prevhf, hf, t;
    logic acc;
    logic [319:0] cap;

    rst = 1'b0; in_valid = 1'b1; abort = 1'b0; out_ready = 1'b1;
    rounds = 2'b00; set_sin('0);
    #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_intial", dp_intial, 0);
    chk("rst_inc", dp_inc, 0);
    chk("rst_sout", {s_out0, s_out1, s_out2, s_out3, s_out4}, 0);
    @(posedge clk); #1;
    chk("rst_edge_valid", out_valid, 0);
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", in_ready, 1);

    // p12 / p6 / p8
    run_req(2'b00, '0, 0);
    run_req(2'b10, rand320(), 0);
    run_req(2'b01, rand320(), 0);
    // consumer stalls for five cycles
    run_req(2'b00, rand320(), 5);

    // abort in IDLE beats acceptance
    wait_idle();
    in_valid = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    chk("abort_idle", in_ready, 1);
    in_valid = 1'b0; abort = 1'b0;

    // abort on third RUN cycle
    wait_idle();
    rounds = 2'b00; set_sin(rand320()); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cap = {s_out0, s_out1, s_out2, s_out3, s_out4};
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_idle_next", in_ready, 1);
    chk("abort_inc", dp_inc, 0);
    chk("abort_sout", {s_out0, s_out1, s_out2, s_out3, s_out4}, cap);
    run_req(2'b01, rand320(), 0);

    // asynchronous reset in the middle of RUN
    wait_idle();
    rounds = 2'b00; set_sin(rand320()); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0; in_valid = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_sout", {s_out0, s_out1, s_out2, s_out3, s_out4}, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_inc", dp_inc, 0);
    chk("arst_intial", dp_intial, 0);
    @(posedge clk); @(posedge clk); #3;
    in_valid = 1'b0; rst = 1'b1;
    run_req(2'b11, rand320(), 0);

    // back-to-back with in_valid held high
    wait_idle();
    in_valid = 1'b1; out_ready = 1'b1;
    rounds = 2'($urandom); set_sin(rand320());
    nacc = 0; prev = -1; prevhf = 0; t = 0;
    while (nacc < 6 && t < 200) begin
      @(negedge clk);
      acc = in_ready;
      hf  = half_of(rounds);
      @(posedge clk); #1;
      t++;
      if (acc) begin
        if (prev >= 0) chk("b2b_interval", t - prev, prevhf + 2);
        prev = t; prevhf = hf; nacc++;
        rounds = 2'($urandom); set_sin(rand320());
      end
    end
    in_valid = 1'b0;
    chk("b2b_count", nacc, 6);

    // randomised tail
    for (int i = 0; i < 4; i++)
      run_req(2'($urandom_range(0, 3)), rand320(), $urandom_range(0, 2));

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
